seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//   Parametrised sequential shift-add multiplier, successor to the 8x8 combinational
//   multiplier. Computes a*b over WIDTH cycles with unsigned or two's-complement
//   mode, valid/ready handshakes on input and output, and an overflow flag (rout).
//   Sits between an operand producer and a result consumer in the datapath.
// PARAMETERS
//   WIDTH   8   operand width in bits, WIDTH >= 2; product is 2*WIDTH bits
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous reset, active-high
//   in_valid     in   1        operands a, b, signed_mode valid
//   in_ready     out  1        block can accept operands (high only in IDLE)
//   a            in   WIDTH    multiplicand
//   b            in   WIDTH    multiplier
//   signed_mode  in   1        1: a, b and m are two's complement; 0: unsigned
//   busy         out  1        high in BUSY state
//   out_valid    out  1        m and rout valid (high only in DONE)
//   out_ready    in   1        consumer accepts result
//   m            out  2*WIDTH  product
//   rout         out  1        product does not fit in WIDTH bits (see below)
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, busy=0, out_valid=0, m=0, rout=0, counter=0.
//   FSM: IDLE -> BUSY on in_valid&in_ready; BUSY -> DONE when counter reaches WIDTH;
//        DONE -> IDLE on out_ready; all other cases hold state.
//   Accept (cycle 0): latch a, b, signed_mode; in signed mode store |a|, |b| as
//     WIDTH-bit unsigned magnitudes and neg = a[W-1]^b[W-1]; else neg=0.
//   BUSY: one partial-product step per cycle (add |a|<<i to accumulator when
//     bit i of |b| set, i=0..WIDTH-1); exactly WIDTH cycles regardless of operand
//     values (zero operands do not shorten latency).
//   Result: out_valid rises WIDTH+1 cycles after the accepting edge; m = neg ?
//     -acc : acc (2*WIDTH-bit two's complement). m and rout are registered and
//     held stable while out_valid=1 and out_ready=0.
//   rout: unsigned mode: m[2W-1:W] != 0. Signed mode: m[2W-1:W-1] not all equal.
//   Width rules: -2^(W-1) * -2^(W-1) = 2^(2W-2) fits in m (no wrap); magnitude of
//     -2^(W-1) is 2^(W-1), representable unsigned in WIDTH bits.
//   in_valid while BUSY or DONE: ignored, operands not latched, in_ready=0.
//   Operand changes after acceptance have no effect on the in-flight product.
//   out_ready while not DONE: ignored. DONE with out_ready=1: out_valid drops next
//     cycle, m and rout keep last value until the next result is written.
//   No back-to-back: next acceptance earliest one cycle after result handoff.
//   rst asserted mid-operation: immediate return to reset values; in-flight
//     operation discarded, no out_valid pulse produced for it.
// TESTING
//   1 unsigned a=217 b=151 -> after 9 cycles out_valid=1, m=16'h7FFF, rout=1
//   2 unsigned a=217 b=21 then a=2 b=2 -> m=16'h11CD rout=1; then m=16'h0004 rout=0
//   3 signed a=8'hFE(-2) b=8'h03 -> m=16'hFFFA rout=0; a=8'h80 b=8'h80 -> m=16'h4000
//     rout=1; a=8'h80 b=8'h01 -> m=16'hFF80 rout=0
//   4 unsigned a=255 b=255 with out_ready=0 for 5 cycles -> m=16'hFE01 rout=1 held,
//     in_valid pulses during BUSY/DONE ignored, in_ready=0 throughout
//   5 rst pulse at BUSY cycle 4 -> all outputs return to reset values asynchronously,
//     no out_valid; next operation a=3 b=5 -> m=16'h000F rout=0
//   6 WIDTH=16 unsigned a=16'hFFFF b=16'h0002 -> after 17 cycles m=32'h0001FFFE rout=1

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH partial-product steps per operation,
// unsigned or two's-complement operands, valid/ready on both sides, overflow flag.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] m,
    output logic               rout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] sh_a;
    logic [WIDTH-1:0]   sh_b;
    logic [2*WIDTH-1:0] acc;
    logic               neg;
    logic               smode;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] res;
    logic [WIDTH:0]     hi;
    logic               rout_c;

    // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude
    always_comb begin
        mag_a = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        mag_b = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    end

    always_comb begin
        res    = neg ? (~acc + (2*WIDTH)'(1)) : acc;
        hi     = res[2*WIDTH-1:WIDTH-1];
        rout_c = smode ? !((&hi) || !(|hi)) : (|res[2*WIDTH-1:WIDTH]);
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt == CNT_MAX) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sh_a  <= '0;
            sh_b  <= '0;
            acc   <= '0;
            neg   <= 1'b0;
            smode <= 1'b0;
            m     <= '0;
            rout  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (in_valid) begin
                    cnt   <= '0;
                    acc   <= '0;
                    sh_a  <= {{WIDTH{1'b0}}, mag_a};
                    sh_b  <= mag_b;
                    neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    smode <= signed_mode;
                end
                // fixed WIDTH steps; the extra cycle at cnt==WIDTH writes the result
                BUSY: if (cnt != CNT_MAX) begin
                    if (sh_b[0]) acc <= acc + sh_a;
                    sh_a <= sh_a << 1;
                    sh_b <= sh_b >> 1;
                    cnt  <= cnt + 1'b1;
                end else begin
                    m    <= res;
                    rout <= rout_c;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed table, handshake/reset corner sequences,
// randomized operands against an arithmetic reference, plus a WIDTH=16 instance.
module tb_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, signed_mode, out_ready;
    logic [7:0]  a, b;
    logic        in_ready, busy, out_valid, rout;
    logic [15:0] m;

    logic        iv_w, sm_w, or_w;
    logic [15:0] a_w, b_w;
    logic        ir_w, busy_w, ov_w, rout_w;
    logic [31:0] m_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .m(m), .rout(rout)
    );

    seq_multiplier #(.WIDTH(16)) dut_w (
        .clk(clk), .rst(rst), .in_valid(iv_w), .in_ready(ir_w),
        .a(a_w), .b(b_w), .signed_mode(sm_w), .busy(busy_w),
        .out_valid(ov_w), .out_ready(or_w), .m(m_w), .rout(rout_w)
    );

    typedef struct {
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_m;
        logic        exp_r;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference: plain integer product and range test
    task automatic model(input logic sm, input logic [7:0] ia, input logic [7:0] ib,
                         output logic [15:0] p, output logic r);
        longint x;
        if (sm) x = longint'($signed(ia)) * longint'($signed(ib));
        else    x = longint'(ia) * longint'(ib);
        p = x[15:0];
        r = sm ? (x < -128 || x > 127) : (x > 255);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_m"}, m, 0);
        chk({tag, "_rout"}, rout, 0);
    endtask

    task automatic run_op(input logic sm, input logic [7:0] ia, input logic [7:0] ib,
                          input int hold, input bit poke,
                          output logic [15:0] rm, output logic rr, output int lat);
        int n;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        signed_mode = sm; a = ia; b = ib; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        // scramble operands: the in-flight product must not see them
        in_valid = poke; a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
        chk("busy_after_accept", {busy, in_ready}, 2'b10);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
            if (poke && !out_valid) chk("in_ready_busy", in_ready, 0);
        end
        chk("out_valid_seen", out_valid, 1);
        lat = n; rm = m; rr = rout;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_result", {rout, m}, {rr, rm});
            if (poke) chk("in_ready_done", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("result_kept", {rout, m}, {rr, rm});
        chk("back_idle", in_ready, 1);
    endtask

    initial begin
        vec_t        vt[$];
        logic [15:0] rm, em;
        logic        rr, er;
        int          lat, n;

        rst = 1'b1; in_valid = 1'b0; signed_mode = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        iv_w = 1'b0; sm_w = 1'b0; or_w = 1'b0; a_w = '0; b_w = '0;
        #12;
        chk_reset_vals("reset");
        @(negedge clk); rst = 1'b0;

        vt.push_back('{1'b0, 8'd217, 8'd151, 16'h7FFF, 1'b1});
        vt.push_back('{1'b0, 8'd217, 8'd21,  16'h11CD, 1'b1});
        vt.push_back('{1'b0, 8'd2,   8'd2,   16'h0004, 1'b0});
        vt.push_back('{1'b1, 8'hFE,  8'h03,  16'hFFFA, 1'b0});
        vt.push_back('{1'b1, 8'h80,  8'h80,  16'h4000, 1'b1});
        vt.push_back('{1'b1, 8'h80,  8'h01,  16'hFF80, 1'b0});
        vt.push_back('{1'b0, 8'h00,  8'h00,  16'h0000, 1'b0});
        vt.push_back('{1'b1, 8'h7F,  8'h7F,  16'h3F01, 1'b1});
        vt.push_back('{1'b1, 8'hFF,  8'hFF,  16'h0001, 1'b0});
        vt.push_back('{1'b0, 8'h0F,  8'h11,  16'h00FF, 1'b0});
        foreach (vt[i]) begin
            run_op(vt[i].sm, vt[i].a, vt[i].b, 0, 1'b0, rm, rr, lat);
            chk($sformatf("vec%0d_m", i), rm, vt[i].exp_m);
            chk($sformatf("vec%0d_rout", i), rr, vt[i].exp_r);
            chk($sformatf("vec%0d_latency", i), lat, 9);
        end

        // stalled consumer with ignored in_valid pulses throughout
        run_op(1'b0, 8'd255, 8'd255, 5, 1'b1, rm, rr, lat);
        chk("stall_m", rm, 16'hFE01);
        chk("stall_rout", rr, 1);
        chk("stall_latency", lat, 9);

        // reset in the middle of BUSY
        @(negedge clk);
        signed_mode = 1'b0; a = 8'd9; b = 8'd9; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2; rst = 1'b1; #1;
        chk_reset_vals("midrst");
        @(negedge clk); rst = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) n++;
        end
        chk("midrst_no_output", n, 0);
        run_op(1'b0, 8'd3, 8'd5, 1, 1'b0, rm, rr, lat);
        chk("post_rst_m", rm, 16'h000F);
        chk("post_rst_rout", rr, 0);

        for (int i = 0; i < 40; i++) begin
            logic       rs;
            logic [7:0] ra, rb;
            rs = 1'($urandom); ra = 8'($urandom); rb = 8'($urandom);
            if (i % 8 == 0) ra = 8'h80;
            model(rs, ra, rb, em, er);
            run_op(rs, ra, rb, int'($urandom_range(0, 2)), 1'($urandom), rm, rr, lat);
            chk($sformatf("rand%0d_m", i), rm, em);
            chk($sformatf("rand%0d_rout", i), rr, er);
        end

        // 16-bit instance
        @(negedge clk);
        a_w = 16'hFFFF; b_w = 16'h0002; sm_w = 1'b0; iv_w = 1'b1;
        @(posedge clk); #1; iv_w = 1'b0;
        n = 0;
        while (!ov_w && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("w16_valid", ov_w, 1);
        chk("w16_latency", n, 17);
        chk("w16_m", m_w, 32'h0001FFFE);
        chk("w16_rout", rout_w, 1);
        or_w = 1'b1;
        @(posedge clk); #1; or_w = 1'b0;
        chk("w16_drop", ov_w, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
